// File: rtl/pool_stream_kxk.sv
// pool_stream_kxk: streaming KxK non-overlapping max / floor-average pooling.
// Pixels arrive in raster order with frame coordinates. A horizontal
// accumulator folds each K-pixel row segment. A column-partial buffer, one
// entry per column group, folds the K row segments of a window. The final
// value leaves two edges after the bottom-right pixel is sampled.
module pool_stream_kxk #(
    parameter int WIDTH      = 4,
    parameter int HEIGHT     = 4,
    parameter int W_WIDTH    = 8,
    parameter int W_HEIGHT   = 8,
    parameter int FIXED_BITW = 8,
    parameter int UNITS      = 2,
    parameter int POOL_SIZE  = 2,
    parameter int MODE       = 0,
    parameter int H_BITW     = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1,
    parameter int V_BITW     = (W_HEIGHT > 1) ? $clog2(W_HEIGHT) : 1
) (
    input  logic                         clock,
    input  logic                         n_rst,
    input  logic                         in_enable,
    input  logic [FIXED_BITW*UNITS-1:0]  in_pixels,
    input  logic [V_BITW-1:0]            in_vcnt,
    input  logic [H_BITW-1:0]            in_hcnt,
    output logic                         out_enable,
    output logic [FIXED_BITW*UNITS-1:0]  out_pixels,
    output logic [V_BITW-1:0]            out_vcnt,
    output logic [H_BITW-1:0]            out_hcnt
);

    localparam int K      = POOL_SIZE;
    localparam int LOG2K  = $clog2(K);
    // Sum of K*K samples needs 2*log2(K) guard bits; max mode just sign-extends.
    localparam int AW     = FIXED_BITW + 2 * LOG2K;
    localparam int SHIFT  = (MODE == 1) ? 2 * LOG2K : 0;
    localparam int NG_H   = WIDTH / K;
    localparam int NG_V   = HEIGHT / K;
    localparam int FULL_W = K * NG_H;
    localparam int FULL_H = K * NG_V;
    localparam int GA_W   = (NG_H > 1) ? $clog2(NG_H) : 1;
    localparam int PH_W   = $clog2(K);
    // One spare bit so K and the full-window limits always fit the counters.
    localparam int HX     = H_BITW + 1;
    localparam int VX     = V_BITW + 1;
    localparam int DW     = UNITS * AW;
    localparam int PW     = UNITS * FIXED_BITW;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(K - 1);

    // Fold two accumulator values: signed max or plain sum.
    function automatic logic [AW-1:0] merge2(input logic [AW-1:0] a,
                                             input logic [AW-1:0] b);
        if (MODE == 0) begin
            return ($signed(a) > $signed(b)) ? a : b;
        end
        return a + b;
    endfunction

    // ---------------- coordinate decode ----------------
    logic [HX-1:0]   hcnt_x, hgrp_x, hph_x;
    logic [VX-1:0]   vcnt_x, vgrp_x, vph_x;
    logic [PH_W-1:0] hph, vph;
    logic            in_full, take, h_first, h_last, rd_en;
    logic [GA_W-1:0] rd_addr;

    assign hcnt_x  = {1'b0, in_hcnt};
    assign vcnt_x  = {1'b0, in_vcnt};
    assign hgrp_x  = hcnt_x / HX'(K);
    assign hph_x   = hcnt_x % HX'(K);
    assign vgrp_x  = vcnt_x / VX'(K);
    assign vph_x   = vcnt_x % VX'(K);
    assign hph     = PH_W'(hph_x);
    assign vph     = PH_W'(vph_x);
    // Only pixels inside complete windows do anything; partial edges are dropped here.
    assign in_full = (hcnt_x < HX'(FULL_W)) && (vcnt_x < VX'(FULL_H));
    assign take    = in_enable && in_full;
    assign h_first = (hph == '0);
    assign h_last  = (hph == LAST_PH);
    assign rd_en   = take && h_last;
    assign rd_addr = GA_W'(hgrp_x);

    // ---------------- state ----------------
    logic [DW-1:0]     acc_reg;
    logic              acc_ok_reg;
    logic              s1_vld_reg, s1_row_ok_reg;
    logic [DW-1:0]     s1_row_reg;
    logic [PH_W-1:0]   s1_vph_reg;
    logic [GA_W-1:0]   s1_grp_reg;
    logic [H_BITW-1:0] s1_hout_reg;
    logic [V_BITW-1:0] s1_vout_reg;
    logic [DW-1:0]     col_mem [0:NG_H-1];
    logic [DW-1:0]     mem_rd_reg;
    logic [NG_H-1:0]   col_ok_reg;
    logic              rd_ok_reg, fwd_hit_reg;
    logic [DW-1:0]     fwd_data_reg;
    logic              s2_vld_reg;
    logic [PW-1:0]     s2_pix_reg;
    logic [H_BITW-1:0] s2_hout_reg;
    logic [V_BITW-1:0] s2_vout_reg;

    // ---------------- per-channel datapath ----------------
    logic [DW-1:0] pix_ext, acc_merge, buf_rd, col_merge;
    logic [PW-1:0] fin_pix;
    logic          col_ok, wr_en, emit;
    logic [GA_W-1:0] wr_addr;

    assign buf_rd = fwd_hit_reg ? fwd_data_reg : mem_rd_reg;

    for (genvar gi = 0; gi < UNITS; gi++) begin : g_ch
        assign pix_ext[gi*AW +: AW]   = AW'($signed(in_pixels[gi*FIXED_BITW +: FIXED_BITW]));
        assign acc_merge[gi*AW +: AW] = merge2(acc_reg[gi*AW +: AW], pix_ext[gi*AW +: AW]);
        // Vertical phase 0 starts a fresh column partial; later rows fold into it.
        assign col_merge[gi*AW +: AW] = (s1_vph_reg == '0) ? s1_row_reg[gi*AW +: AW]
                                      : merge2(buf_rd[gi*AW +: AW], s1_row_reg[gi*AW +: AW]);
        // Arithmetic shift gives floor toward -inf; result always fits FIXED_BITW.
        assign fin_pix[gi*FIXED_BITW +: FIXED_BITW] =
            FIXED_BITW'($signed(col_merge[gi*AW +: AW]) >>> SHIFT);
    end

    // A window is only trusted if every row segment started from its phase-0 pixel.
    assign col_ok  = s1_row_ok_reg && ((s1_vph_reg == '0) || rd_ok_reg);
    assign wr_en   = s1_vld_reg && (s1_vph_reg != LAST_PH);
    assign wr_addr = s1_grp_reg;
    assign emit    = s1_vld_reg && (s1_vph_reg == LAST_PH) && col_ok;

    // Horizontal accumulator: load on phase 0, fold on middle phases, hold on idle cycles.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            acc_reg    <= '0;
            acc_ok_reg <= 1'b0;
        end else if (take) begin
            if (h_first) begin
                acc_reg    <= pix_ext;
                acc_ok_reg <= 1'b1;
            end else if (h_last) begin
                acc_ok_reg <= 1'b0;
            end else begin
                acc_reg <= acc_merge;
            end
        end
    end

    // Stage 1: completed row segment plus its window coordinates.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            s1_vld_reg    <= 1'b0;
            s1_row_reg    <= '0;
            s1_row_ok_reg <= 1'b0;
            s1_vph_reg    <= '0;
            s1_grp_reg    <= '0;
            s1_hout_reg   <= '0;
            s1_vout_reg   <= '0;
        end else begin
            s1_vld_reg <= rd_en;
            if (rd_en) begin
                s1_row_reg    <= acc_merge;
                s1_row_ok_reg <= acc_ok_reg;
                s1_vph_reg    <= vph;
                s1_grp_reg    <= rd_addr;
                s1_hout_reg   <= H_BITW'(hgrp_x);
                s1_vout_reg   <= V_BITW'(vgrp_x);
            end
        end
    end

    // Column-partial buffer storage with registered read (no reset on the data).
    always_ff @(posedge clock) begin
        if (wr_en) begin
            col_mem[wr_addr] <= col_merge;
        end
        if (rd_en) begin
            mem_rd_reg <= col_mem[rd_addr];
        end
    end

    // Per-entry valid bits and write-to-read forwarding for a same-edge hit.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            col_ok_reg   <= '0;
            rd_ok_reg    <= 1'b0;
            fwd_hit_reg  <= 1'b0;
            fwd_data_reg <= '0;
        end else begin
            if (wr_en) begin
                col_ok_reg[wr_addr] <= col_ok;
            end
            if (rd_en) begin
                fwd_hit_reg  <= wr_en && (wr_addr == rd_addr);
                fwd_data_reg <= col_merge;
                rd_ok_reg    <= (wr_en && (wr_addr == rd_addr)) ? col_ok : col_ok_reg[rd_addr];
            end
        end
    end

    // Stage 2: finished window result.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            s2_vld_reg  <= 1'b0;
            s2_pix_reg  <= '0;
            s2_hout_reg <= '0;
            s2_vout_reg <= '0;
        end else begin
            s2_vld_reg <= emit;
            if (emit) begin
                s2_pix_reg  <= fin_pix;
                s2_hout_reg <= s1_hout_reg;
                s2_vout_reg <= s1_vout_reg;
            end
        end
    end

    // Output register: one-cycle valid pulse, data held between pulses.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_enable <= 1'b0;
            out_pixels <= '0;
            out_hcnt   <= '0;
            out_vcnt   <= '0;
        end else begin
            out_enable <= s2_vld_reg;
            if (s2_vld_reg) begin
                out_pixels <= s2_pix_reg;
                out_hcnt   <= s2_hout_reg;
                out_vcnt   <= s2_vout_reg;
            end
        end
    end

endmodule

// File: tb/tb_pool_stream_kxk.sv
// Bench for pool_stream_kxk: four parameterisations share the input bus, each
// with its own enable. A window model pushes expected pulses when the
// bottom-right pixel is driven; a monitor pops them as pulses appear.
module tb_pool_stream_kxk;

    typedef struct {
        int          d;
        logic [15:0] pix;
        logic [3:0]  v;
        logic [3:0]  h;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        rst_a, rst_g;
    logic        en [4];
    logic [15:0] pixels;
    logic [3:0]  hcnt, vcnt;
    logic        oe [4];
    logic [15:0] op [4];
    logic [3:0]  ov [4];
    logic [3:0]  oh [4];

    int   img [2][16][16];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pulses [4];
    logic [15:0] last_pix [4];

    pool_stream_kxk #(.WIDTH(4), .HEIGHT(4), .W_WIDTH(12), .W_HEIGHT(10), .FIXED_BITW(8),
                      .UNITS(2), .POOL_SIZE(2), .MODE(0)) dut_a (
        .clock(clock), .n_rst(rst_a), .in_enable(en[0]), .in_pixels(pixels),
        .in_vcnt(vcnt), .in_hcnt(hcnt), .out_enable(oe[0]), .out_pixels(op[0]),
        .out_vcnt(ov[0]), .out_hcnt(oh[0]));

    pool_stream_kxk #(.WIDTH(4), .HEIGHT(4), .W_WIDTH(12), .W_HEIGHT(10), .FIXED_BITW(8),
                      .UNITS(2), .POOL_SIZE(2), .MODE(1)) dut_b (
        .clock(clock), .n_rst(rst_g), .in_enable(en[1]), .in_pixels(pixels),
        .in_vcnt(vcnt), .in_hcnt(hcnt), .out_enable(oe[1]), .out_pixels(op[1]),
        .out_vcnt(ov[1]), .out_hcnt(oh[1]));

    pool_stream_kxk #(.WIDTH(8), .HEIGHT(7), .W_WIDTH(12), .W_HEIGHT(10), .FIXED_BITW(8),
                      .UNITS(2), .POOL_SIZE(3), .MODE(0)) dut_c (
        .clock(clock), .n_rst(rst_g), .in_enable(en[2]), .in_pixels(pixels),
        .in_vcnt(vcnt), .in_hcnt(hcnt), .out_enable(oe[2]), .out_pixels(op[2]),
        .out_vcnt(ov[2]), .out_hcnt(oh[2]));

    pool_stream_kxk #(.WIDTH(16), .HEIGHT(8), .W_WIDTH(16), .W_HEIGHT(10), .FIXED_BITW(8),
                      .UNITS(2), .POOL_SIZE(4), .MODE(1)) dut_d (
        .clock(clock), .n_rst(rst_g), .in_enable(en[3]), .in_pixels(pixels),
        .in_vcnt(vcnt), .in_hcnt(hcnt), .out_enable(oe[3]), .out_pixels(op[3]),
        .out_vcnt(ov[3]), .out_hcnt(oh[3]));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference window value for one channel: signed max or floor(sum / K*K).
    function automatic logic [7:0] win_val(input int c, input int gy, input int gx,
                                           input int k, input int mode);
        int m, s;
        m = -1000;
        s = 0;
        for (int y = 0; y < k; y++) begin
            for (int x = 0; x < k; x++) begin
                if (img[c][gy*k+y][gx*k+x] > m) m = img[c][gy*k+y][gx*k+x];
                s += img[c][gy*k+y][gx*k+x];
            end
        end
        if (mode == 1) return 8'(s >>> (2 * $clog2(k)));
        return 8'(m);
    endfunction

    function automatic int pending(input int d);
        int n;
        n = 0;
        foreach (sb[i]) if (sb[i].d == d) n++;
        return n;
    endfunction

    task automatic fill_random(input int lo, input int hi);
        for (int c = 0; c < 2; c++)
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    img[c][y][x] = lo + int'($urandom_range(0, hi - lo));
    endtask

    // Stream one frame into DUT d; blank>0 adds blanking columns and one blank row.
    task automatic drive_frame(input int d, input int wd, input int ht, input int k,
                               input int mode, input int blank, input int duty);
        int rows;
        rows = (blank > 0) ? ht + 1 : ht;
        for (int v = 0; v < rows; v++) begin
            for (int h = 0; h < wd + blank; h++) begin
                int gaps;
                exp_t e;
                gaps = 0;
                while (duty < 100 && gaps < 10 && $urandom_range(0, 99) >= duty) begin
                    @(posedge clock); #1;
                    en[d] = 1'b0;
                    gaps++;
                end
                @(posedge clock); #1;
                en[d]  = 1'b1;
                hcnt   = 4'(h);
                vcnt   = 4'(v);
                pixels = {8'(img[1][v][h]), 8'(img[0][v][h])};
                if (v < k*(ht/k) && h < k*(wd/k) && (v % k == k-1) && (h % k == k-1)) begin
                    e.d   = d;
                    e.pix = {win_val(1, v/k, h/k, k, mode), win_val(0, v/k, h/k, k, mode)};
                    e.v   = 4'(v / k);
                    e.h   = 4'(h / k);
                    e.cyc = cyc + 3;
                    sb.push_back(e);
                end
            end
        end
        @(posedge clock); #1;
        en[d] = 1'b0;
    endtask

    // Scoreboard monitor: match every pulse, and check outputs hold between pulses.
    task automatic monitor();
        forever begin
            @(negedge clock);
            for (int d = 0; d < 4; d++) begin
                int   idx;
                exp_t e;
                logic rn;
                idx = -1;
                rn  = (d == 0) ? rst_a : rst_g;
                if (oe[d] === 1'b1) begin
                    pulses[d]++;
                    total++;
                    foreach (sb[i]) if (idx < 0 && sb[i].d == d) idx = i;
                    if (idx < 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse dut%0d: got pix=%h v=%0d h=%0d, required no pulse",
                                 d, op[d], ov[d], oh[d]);
                    end else begin
                        e = sb[idx];
                        sb.delete(idx);
                        if (op[d] !== e.pix || ov[d] !== e.v || oh[d] !== e.h || cyc != e.cyc) begin
                            bad++;
                            $display("FAIL pulse dut%0d: got pix=%h v=%0d h=%0d cyc=%0d, required pix=%h v=%0d h=%0d cyc=%0d",
                                     d, op[d], ov[d], oh[d], cyc, e.pix, e.v, e.h, e.cyc);
                        end else begin
                            $display("pulse dut%0d pix=%h v=%0d h=%0d cyc=%0d ok", d, op[d], ov[d], oh[d], cyc);
                        end
                    end
                    last_pix[d] = op[d];
                end else if (rn !== 1'b1) begin
                    last_pix[d] = 16'h0;
                end else begin
                    total++;
                    if (op[d] !== last_pix[d]) begin
                        bad++;
                        $display("FAIL hold dut%0d: got pix=%h, required %h", d, op[d], last_pix[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 4; d++) begin
            total++;
            if (oe[d] !== 1'b0 || op[d] !== 16'h0 || ov[d] !== 4'h0 || oh[d] !== 4'h0) begin
                bad++;
                $display("FAIL reset_state dut%0d: got en=%b pix=%h v=%h h=%h, required all zero",
                         d, oe[d], op[d], ov[d], oh[d]);
            end
        end
        rst_a = 1'b1;
        rst_g = 1'b1;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_max_2x2();
        int p0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                img[0][y][x] = (y < 4 && x < 4) ? y*4 + x : 99;
                img[1][y][x] = (y < 4 && x < 4) ? -(y*4 + x) : 99;
            end
        p0 = pulses[0];
        drive_frame(0, 4, 4, 2, 0, 3, 100);
        repeat (6) @(posedge clock);
        #1;
        total++;
        if (pulses[0] - p0 != 4 || pending(0) != 0) begin
            bad++;
            $display("FAIL max2_count: got %0d pulses (%0d missing), required 4", pulses[0] - p0, pending(0));
        end
        total++;
        if (op[0] !== 16'hF60F) begin
            bad++;
            $display("FAIL max2_last: got %h, required f60f", op[0]);
        end
    endtask

    task automatic test_avg_2x2();
        int p0;
        fill_random(-128, 127);
        img[0][0][0] = -1;   img[0][0][1] = -2;   img[0][1][0] = 0;    img[0][1][1] = 0;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 2; x++) begin
                img[0][y][x+2] = 127;
                img[0][y+2][x] = -128;
            end
        p0 = pulses[1];
        drive_frame(1, 4, 4, 2, 1, 3, 100);
        repeat (6) @(posedge clock);
        #1;
        total++;
        if (pulses[1] - p0 != 4 || pending(1) != 0) begin
            bad++;
            $display("FAIL avg2_count: got %0d pulses (%0d missing), required 4", pulses[1] - p0, pending(1));
        end
    endtask

    task automatic test_partial_k3();
        int p0;
        fill_random(-128, 100);
        // Edge pixels are the largest value: any leak shows up as 127 in a max.
        for (int y = 0; y < 7; y++) begin
            img[0][y][6] = 127; img[0][y][7] = 127;
            img[1][y][6] = 127; img[1][y][7] = 127;
        end
        for (int x = 0; x < 8; x++) begin
            img[0][6][x] = 127; img[1][6][x] = 127;
        end
        p0 = pulses[2];
        drive_frame(2, 8, 7, 3, 0, 2, 100);
        repeat (6) @(posedge clock);
        #1;
        total++;
        if (pulses[2] - p0 != 4 || pending(2) != 0) begin
            bad++;
            $display("FAIL k3_count: got %0d pulses (%0d missing), required 4", pulses[2] - p0, pending(2));
        end
    endtask

    task automatic test_avg_k4_gaps();
        int p0;
        p0 = pulses[3];
        for (int f = 0; f < 2; f++) begin
            fill_random(-128, 127);
            drive_frame(3, 16, 8, 4, 1, 0, 30);
        end
        repeat (6) @(posedge clock);
        #1;
        total++;
        if (pulses[3] - p0 != 16 || pending(3) != 0) begin
            bad++;
            $display("FAIL k4_count: got %0d pulses (%0d missing), required 16", pulses[3] - p0, pending(3));
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        fill_random(-128, 127);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            en[0]  = 1'b1;
            hcnt   = 4'(i % 4);
            vcnt   = 4'(i / 4);
            pixels = {8'(img[1][i/4][i%4]), 8'(img[0][i/4][i%4])};
        end
        @(posedge clock); #1;
        en[0] = 1'b0;
        rst_a = 1'b0;
        #1;
        total++;
        if (oe[0] !== 1'b0 || op[0] !== 16'h0 || ov[0] !== 4'h0 || oh[0] !== 4'h0) begin
            bad++;
            $display("FAIL async_reset: got en=%b pix=%h v=%h h=%h, required all zero", oe[0], op[0], ov[0], oh[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if (oe[0] !== 1'b0 || op[0] !== 16'h0) begin
                bad++;
                $display("FAIL in_reset: got en=%b pix=%h, required 0 0000", oe[0], op[0]);
            end
        end
        @(posedge clock); #1;
        rst_a = 1'b1;
        p0 = pulses[0];
        fill_random(-128, 127);
        drive_frame(0, 4, 4, 2, 0, 3, 100);
        repeat (6) @(posedge clock);
        #1;
        total++;
        if (pulses[0] - p0 != 4 || pending(0) != 0) begin
            bad++;
            $display("FAIL post_reset_count: got %0d pulses (%0d missing), required 4", pulses[0] - p0, pending(0));
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses[0];
        fill_random(127, 127);
        drive_frame(0, 4, 4, 2, 0, 0, 100);
        fill_random(-128, -1);
        drive_frame(0, 4, 4, 2, 0, 0, 100);
        repeat (6) @(posedge clock);
        #1;
        total++;
        if (pulses[0] - p0 != 8 || pending(0) != 0) begin
            bad++;
            $display("FAIL b2b_count: got %0d pulses (%0d missing), required 8", pulses[0] - p0, pending(0));
        end
    endtask

    initial begin
        clock  = 1'b0;
        rst_a  = 1'b0;
        rst_g  = 1'b0;
        pixels = '0;
        hcnt   = '0;
        vcnt   = '0;
        for (int d = 0; d < 4; d++) begin
            en[d]       = 1'b0;
            pulses[d]   = 0;
            last_pix[d] = 16'h0;
        end
        fork
            monitor();
        join_none
        test_reset();
        test_max_2x2();
        test_avg_2x2();
        test_partial_k3();
        test_avg_k4_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d unmatched expectations, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
